// File: rtl/ascon_arb_pkg.sv
// ascon_arb_pkg: shared types and widths for the two-requester ASCON core arbiter.
package ascon_arb_pkg;

  localparam int NREQ   = 2;
  localparam int BLK_W  = 64;
  localparam int KEY_W  = 128;
  localparam int LEN_W  = 4;
  localparam int WDT_W  = 16;
  localparam int MODE_W = 2;

  // Arbiter job phases: wait for a request, kick the core, wait for the tag.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/ascon_arb_rr_pick.sv
// rr_pick: two-way round-robin winner selection.
// A lone requester always wins; on a tie the requester that was not granted
// last time wins. Output is one-hot, or zero when nobody requests.
module rr_pick
  import ascon_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last_gnt,
  output logic [NREQ-1:0] pick
);

  // Resolve the winner from the request vector and the previous grant.
  always_comb begin
    pick = '0;
    unique case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_gnt ? 2'b01 : 2'b10;
      default: pick = '0;
    endcase
  end

endmodule

// File: rtl/ascon_arb.sv
// ascon_arb: shares one ASCON AEAD core between two requesters.
// A job is granted in IDLE, the core is kicked for one cycle in START, and the
// grant is held through RUN until the core reports the tag.
// Optional feature macro: ASCON_ARB_WDT_EN adds a RUN-phase watchdog that
// aborts a job after WDT_LIMIT cycles without a tag and pulses err_o.
module ascon_arb
  import ascon_arb_pkg::*;
#(
  parameter int WDT_LIMIT = 4096
) (
  input  logic                        clk,
  input  logic                        nRST,
  input  logic [NREQ-1:0]             req_i,
  input  logic [NREQ-1:0][MODE_W-1:0] mode_i,
  input  logic [NREQ-1:0][KEY_W-1:0]  key_i,
  input  logic [NREQ-1:0][KEY_W-1:0]  nonce_i,
  input  logic [NREQ-1:0][BLK_W-1:0]  blk_i,
  input  logic [NREQ-1:0][LEN_W-1:0]  blklen_i,
  output logic [NREQ-1:0]             gnt_o,
  output logic [NREQ-1:0]             blk_rd_o,
  output logic [NREQ-1:0]             ct_valid_o,
  output logic [NREQ-1:0]             done_o,
  output logic [NREQ-1:0]             err_o,
  output logic                        core_start_o,
  output logic [MODE_W-1:0]           core_mode_o,
  output logic [KEY_W-1:0]            core_key_o,
  output logic [KEY_W-1:0]            core_nonce_o,
  output logic [BLK_W-1:0]            core_blockin_o,
  output logic [LEN_W-1:0]            core_datalen_o,
  input  logic                        core_blk_rd_i,
  input  logic                        core_ctv_i,
  input  logic                        core_tv_i
);

  state_t          state_reg;
  logic [NREQ-1:0] gnt_reg;
  logic            last_gnt_reg;
  logic [NREQ-1:0] done_reg;
  logic [NREQ-1:0] err_reg;
  logic            start_reg;
  logic [NREQ-1:0] pick;
  logic            in_run;
  logic            wdt_hit;

  rr_pick u_rr_pick (
    .req      (req_i),
    .last_gnt (last_gnt_reg),
    .pick     (pick)
  );

  assign in_run = (state_reg == ST_RUN);

`ifdef ASCON_ARB_WDT_EN
  logic [WDT_W-1:0] wdt_cnt_reg;

  // Watchdog counts RUN cycles; it restarts from zero at every core kick.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      wdt_cnt_reg <= '0;
    end else if (state_reg == ST_START) begin
      wdt_cnt_reg <= '0;
    end else if (in_run) begin
      wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
    end
  end

  // Expire on the RUN cycle whose increment would reach the limit.
  assign wdt_hit = in_run && ((wdt_cnt_reg + 1'b1) == WDT_W'(WDT_LIMIT));
`else
  assign wdt_hit = 1'b0;
`endif

  // Job sequencer with registered grant, kick and completion pulses.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= '0;
      last_gnt_reg <= 1'b1;
      done_reg     <= '0;
      err_reg      <= '0;
      start_reg    <= 1'b0;
    end else begin
      done_reg  <= '0;
      err_reg   <= '0;
      start_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (|req_i) begin
            gnt_reg      <= pick;
            last_gnt_reg <= pick[1];
            start_reg    <= 1'b1;
            state_reg    <= ST_START;
          end
        end
        ST_START: begin
          state_reg <= ST_RUN;
        end
        ST_RUN: begin
          // A tag in the expiry cycle still counts as a normal completion.
          if (core_tv_i) begin
            done_reg  <= gnt_reg;
            gnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end else if (wdt_hit) begin
            err_reg   <= gnt_reg;
            gnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          gnt_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Steer the granted requester's job parameters to the core; zero when idle.
  always_comb begin
    core_mode_o    = '0;
    core_key_o     = '0;
    core_nonce_o   = '0;
    core_blockin_o = '0;
    core_datalen_o = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (gnt_reg[r]) begin
        core_mode_o    = mode_i[r];
        core_key_o     = key_i[r];
        core_nonce_o   = nonce_i[r];
        core_blockin_o = blk_i[r];
        core_datalen_o = blklen_i[r];
      end
    end
  end

  // Core handshakes only reach the owner while the job is running.
  assign blk_rd_o     = {NREQ{core_blk_rd_i & in_run}} & gnt_reg;
  assign ct_valid_o   = {NREQ{core_ctv_i & in_run}} & gnt_reg;
  assign gnt_o        = gnt_reg;
  assign done_o       = done_reg;
  assign err_o        = err_reg;
  assign core_start_o = start_reg;

endmodule

// File: tb/tb_ascon_arb.sv
// tb_ascon_arb: directed scenarios followed by random traffic, all checked
// against a job-level reference model of the arbiter.
// Build with ASCON_ARB_WDT_EN to exercise the watchdog with a limit of 8.
module tb_ascon_arb;

`ifdef ASCON_ARB_WDT_EN
  localparam int LIM = 8;
`else
  localparam int LIM = 4096;
`endif

  logic                clk = 1'b0;
  logic                nRST;
  logic [1:0]          req_i;
  logic [1:0][1:0]     mode_i;
  logic [1:0][127:0]   key_i;
  logic [1:0][127:0]   nonce_i;
  logic [1:0][63:0]    blk_i;
  logic [1:0][3:0]     blklen_i;
  logic [1:0]          gnt_o, blk_rd_o, ct_valid_o, done_o, err_o;
  logic                core_start_o;
  logic [1:0]          core_mode_o;
  logic [127:0]        core_key_o, core_nonce_o;
  logic [63:0]         core_blockin_o;
  logic [3:0]          core_datalen_o;
  logic                core_blk_rd_i, core_ctv_i, core_tv_i;

  always #5 clk = ~clk;

  ascon_arb #(.WDT_LIMIT(LIM)) dut (
    .clk            (clk),
    .nRST           (nRST),
    .req_i          (req_i),
    .mode_i         (mode_i),
    .key_i          (key_i),
    .nonce_i        (nonce_i),
    .blk_i          (blk_i),
    .blklen_i       (blklen_i),
    .gnt_o          (gnt_o),
    .blk_rd_o       (blk_rd_o),
    .ct_valid_o     (ct_valid_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .core_start_o   (core_start_o),
    .core_mode_o    (core_mode_o),
    .core_key_o     (core_key_o),
    .core_nonce_o   (core_nonce_o),
    .core_blockin_o (core_blockin_o),
    .core_datalen_o (core_datalen_o),
    .core_blk_rd_i  (core_blk_rd_i),
    .core_ctv_i     (core_ctv_i),
    .core_tv_i      (core_tv_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: who owns the core, how far into the job, last winner.
  int owner     = -1;   // -1: no job
  int age       = 0;    // 0: kick cycle, 1: running
  int run_cnt   = 0;    // RUN cycles seen without a tag
  int last_win  = 1;
  int exp_start = 0;
  int exp_done  = -1;   // requester whose done pulse is due, -1 none
  int exp_err   = -1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int r);
    logic [1:0] v;
    v = '0;
    if (r >= 0) v[r] = 1'b1;
    return v;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check the
  // combinational paths, then advance the model with those inputs.
  task automatic step(input logic rst_n, input logic [1:0] rq,
                      input logic tv, input logic ctv, input logic brd);
    logic running;
    chk("gnt",   {126'd0, gnt_o},        {126'd0, onehot(owner)});
    chk("start", {127'd0, core_start_o}, {127'd0, exp_start[0]});
    chk("done",  {126'd0, done_o},       {126'd0, onehot(exp_done)});
    chk("err",   {126'd0, err_o},        {126'd0, onehot(exp_err)});

    nRST          = rst_n;
    req_i         = rq;
    core_tv_i     = tv;
    core_ctv_i    = ctv;
    core_blk_rd_i = brd;
    for (int r = 0; r < 2; r++) begin
      mode_i[r]   = 2'($urandom_range(0, 3));
      key_i[r]    = {$urandom(), $urandom(), $urandom(), $urandom()};
      nonce_i[r]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      blk_i[r]    = {$urandom(), $urandom()};
      blklen_i[r] = 4'($urandom_range(0, 15));
    end
    #1;
    running = (owner >= 0) && (age >= 1);
    chk("blk_rd",  {126'd0, blk_rd_o},   {126'd0, (running && brd) ? onehot(owner) : 2'b00});
    chk("ct_val",  {126'd0, ct_valid_o}, {126'd0, (running && ctv) ? onehot(owner) : 2'b00});
    chk("c_key",   core_key_o,   (owner >= 0) ? key_i[owner]   : 128'd0);
    chk("c_nonce", core_nonce_o, (owner >= 0) ? nonce_i[owner] : 128'd0);
    chk("c_misc",  {58'd0, core_mode_o, core_datalen_o, core_blockin_o},
        (owner >= 0) ? {58'd0, mode_i[owner], blklen_i[owner], blk_i[owner]} : 128'd0);

    exp_start = 0;
    exp_done  = -1;
    exp_err   = -1;
    if (!rst_n) begin
      owner    = -1;
      last_win = 1;
    end else if (owner < 0) begin
      if (rq != 2'b00) begin
        if (rq == 2'b01)      owner = 0;
        else if (rq == 2'b10) owner = 1;
        else                  owner = (last_win == 0) ? 1 : 0;
        last_win  = owner;
        age       = 0;
        run_cnt   = 0;
        exp_start = 1;
      end
    end else if (age == 0) begin
      age = 1;
    end else if (tv) begin
      $display("[TB] job r=%0d done at cycle %0d", owner, cyc);
      exp_done = owner;
      owner    = -1;
    end else begin
      run_cnt++;
`ifdef ASCON_ARB_WDT_EN
      if (run_cnt == LIM) begin
        $display("[TB] job r=%0d timed out at cycle %0d", owner, cyc);
        exp_err = owner;
        owner   = -1;
      end
`endif
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input logic [1:0] rq);
    for (int i = 0; i < n; i++) step(1'b1, rq, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    nRST = 1'b0; req_i = '0; mode_i = '0; key_i = '0; nonce_i = '0;
    blk_i = '0; blklen_i = '0; core_blk_rd_i = 1'b0; core_ctv_i = 1'b0; core_tv_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b11, 1'b1, 1'b1, 1'b1);

    // Single request, kick, stray tag in IDLE ignored, short job.
    idle(3, 2'b00);
    step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1);   // tag during START ignored
    idle(5, 2'b10);                        // other requester cannot steal grant
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'b00, 1'b1, 1'b1, 1'b0);   // tag with ct valid
    idle(3, 2'b00);

    // Tie after reset goes to 0, next tie to 1.
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(4, 2'b11);
    step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    idle(4, 2'b11);
    step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);

    // Reset mid-job aborts silently, then a tie goes to 0 again.
    idle(3, 2'b00);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(4, 2'b11);
    step(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);

    // Long job with no tag: watchdog fires, or nothing fires at all.
    idle(2, 2'b00);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) step(1'b1, 2'b00, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(2, 2'b00);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0));
    end
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_arb.md
ASCON_ARB -- requirements
Module: ascon_arb

Interface
REQ-001 SHALL have parameter WDT_LIMIT, default 4096, watchdog cycle limit (used only with ASCON_ARB_WDT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_i  input  [1:0]  job request per requester r (r=0,1).
REQ-005 SHALL have port mode_i  input  [1:0][1:0]  AEAD mode per requester.
REQ-006 SHALL have ports key_i and nonce_i  input  [1:0][127:0]  key/nonce per requester.
REQ-007 SHALL have ports blk_i  input  [1:0][63:0] and blklen_i  input  [1:0][3:0]  next data block and byte length per requester.
REQ-008 SHALL have ports gnt_o  output  [1:0]  grant (one-hot or zero); blk_rd_o  output  [1:0]  block consumed; ct_valid_o  output  [1:0]  ciphertext valid; done_o  output  [1:0]  job-complete pulse; err_o  output  [1:0]  watchdog abort pulse.
REQ-009 SHALL have core-side ports core_start_o  output  1; core_mode_o  output  2; core_key_o, core_nonce_o  output  128; core_blockin_o  output  64; core_datalen_o  output  4.
REQ-010 SHALL have core-side inputs core_blk_rd_i  1  (core consumed blockin), core_ctv_i  1  (CT block valid), core_tv_i  1  (tag valid, job end).

Function
REQ-011 SHALL implement FSM IDLE -> START -> RUN -> IDLE; encoding from package.
REQ-012 IDLE: if req_i!=0 in cycle N, SHALL register winner; gnt_o one-hot and state START in cycle N+1.
REQ-013 Arbitration SHALL be round-robin: single request wins; both requesting -> requester not equal to last_gnt wins; last_gnt updates on each grant.
REQ-014 START: core_start_o SHALL be high exactly one cycle, then state RUN.
REQ-015 core_mode_o, core_key_o, core_nonce_o, core_blockin_o, core_datalen_o SHALL be combinational muxes of granted requester's inputs; all-zero when gnt_o==0.
REQ-016 blk_rd_o[g] SHALL equal core_blk_rd_i & gnt_o[g]; ct_valid_o[g] SHALL equal core_ctv_i & gnt_o[g] (combinational, same cycle).
REQ-017 RUN: core_tv_i high in cycle M -> done_o[g] pulses one cycle and gnt_o clears in cycle M+1, state IDLE.
REQ-018 Earliest next grant SHALL be cycle M+2 (one idle cycle between jobs guaranteed).
REQ-019 Grant SHALL be held until job end regardless of req_i deassertion or other requester's req_i.
REQ-020 core_blk_rd_i, core_ctv_i, core_tv_i asserted in IDLE or START SHALL be ignored (no output pulse).
REQ-021 core_tv_i and core_ctv_i in the same RUN cycle SHALL produce both ct_valid_o and subsequent done_o.

Reset
REQ-022 nRST low at clock edge SHALL force state IDLE, gnt_o=0, done_o=0, err_o=0, core_start_o=0, last_gnt=1 (requester 0 wins first tie), watchdog counter=0.
REQ-023 Reset mid-job SHALL abort without done_o or err_o pulse.

Configuration
REQ-024 With ASCON_ARB_WDT_EN defined: 16-bit counter clears on START, increments each RUN cycle; reaching WDT_LIMIT without core_tv_i -> err_o[g] one-cycle pulse, gnt_o cleared, state IDLE next cycle, no done_o.
REQ-025 Without ASCON_ARB_WDT_EN: no counter logic, err_o tied 0, RUN waits indefinitely for core_tv_i.

Structure
REQ-026 Package ascon_arb_pkg SHALL hold state enum, NREQ=2, BLK_W=64, KEY_W=128, LEN_W=4, WDT_W=16.
REQ-027 Sub-module rr_pick SHALL compute winner from req and last_gnt (combinational, 2-way).

Verification
REQ-028 req_i=01 at cycle 10 -> gnt_o=01 and core_start_o pulse at cycle 11; core_tv_i at 40 -> done_o=01 at 41, gnt_o=00 at 41.
REQ-029 After reset req_i=11 -> gnt 01; after that job ends, req_i=11 still -> gnt 10 two cycles after core_tv_i.
REQ-030 During grant to 0, drive req_i=10 and core_blk_rd_i x3 -> blk_rd_o=01 three times, core_blockin_o equals blk_i[0], gnt unchanged.
REQ-031 nRST low during RUN -> next cycle gnt_o=0, done_o=0, err_o=0; following req_i=11 -> gnt 01.
REQ-032 WDT_EN, WDT_LIMIT=8, no core_tv_i -> err_o pulse 8 RUN cycles after START, gnt_o=0; without macro err_o stays 0 for 1000 cycles.
REQ-033 core_tv_i pulsed in IDLE -> no done_o, no state change.
